// File: rtl/estagio_ex_alu_pkg.sv
// Shared definitions for the MIPS execute stage: ALU operation codes (same
// encoding as the ALU control decoder) and the EX/MEM buffer occupancy states.
package estagio_ex_alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_NOR = 4'b0110;
  localparam logic [3:0] ALU_XOR = 4'b0111;
  localparam logic [3:0] ALU_SLT = 4'b1000;

  typedef enum logic [1:0] {
    VAZIO = 2'd0,
    UM    = 2'd1,
    CHEIO = 2'd2
  } estado_t;

endpackage

// File: rtl/alu_nucleo.sv
// Combinational ALU core: decodes the 4-bit control code and produces the
// result plus zero/overflow/invalid-code flags.
module alu_nucleo
  import estagio_ex_alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [3:0]        codigo,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic [DATA_W-1:0] resultado,
  output logic              zero,
  output logic              overflow,
  output logic              invalido
);

  logic signed [DATA_W-1:0] a_s;
  logic signed [DATA_W-1:0] b_s;
  logic signed [DATA_W-1:0] soma;
  logic signed [DATA_W-1:0] dif;

  // Signed overflow: operands point the same way (after negating B for SUB)
  // but the wrapped result has the opposite sign of A.
  function automatic logic ovf_detect(input logic sa, input logic sb_eff,
                                      input logic sr);
    return (sa == sb_eff) && (sr != sa);
  endfunction

  assign a_s  = op_a;
  assign b_s  = op_b;
  assign soma = a_s + b_s;
  assign dif  = a_s - b_s;

  always_comb begin
    resultado = '0;
    overflow  = 1'b0;
    invalido  = 1'b0;
    case (codigo)
      ALU_ADD: begin
        resultado = soma;
        overflow  = ovf_detect(a_s[DATA_W-1], b_s[DATA_W-1], soma[DATA_W-1]);
      end
      ALU_SUB: begin
        resultado = dif;
        overflow  = ovf_detect(a_s[DATA_W-1], ~b_s[DATA_W-1], dif[DATA_W-1]);
      end
      ALU_AND: resultado = a_s & b_s;
      ALU_OR:  resultado = a_s | b_s;
      ALU_NOR: resultado = ~(a_s | b_s);
      ALU_XOR: resultado = a_s ^ b_s;
      ALU_SLT: resultado = DATA_W'(a_s < b_s);
      default: invalido  = 1'b1;
    endcase
  end

  assign zero = (resultado == '0);

endmodule

// File: rtl/estagio_ex_alu.sv
// MIPS execute stage: ALU at the input, then an EX/MEM output register backed
// by a one-entry skid buffer so the upstream ready is purely registered.
module estagio_ex_alu
  import estagio_ex_alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              In_Valido,
  output logic              In_Pronto,
  input  logic [3:0]        Controle_ALU,
  input  logic [DATA_W-1:0] Operando_A,
  input  logic [DATA_W-1:0] Operando_B,
  input  logic [REG_W-1:0]  Reg_Destino,
  input  logic              Escreve_Reg,
  input  logic              Flush,
  output logic              Out_Valido,
  input  logic              Out_Pronto,
  output logic [DATA_W-1:0] Resultado,
  output logic              Zero,
  output logic              Overflow,
  output logic              Codigo_Invalido,
  output logic [REG_W-1:0]  Reg_Destino_Out,
  output logic              Escreve_Reg_Out
);

  typedef struct packed {
    logic [DATA_W-1:0] res;
    logic              zero;
    logic              ovf;
    logic              inv;
    logic [REG_W-1:0]  rd;
    logic              we;
  } entrada_t;

  estado_t  estado_q, estado_d;
  logic     pronto_q, pronto_d;
  entrada_t saida_q, saida_d;
  entrada_t skid_q, skid_d;
  entrada_t novo;

  logic [DATA_W-1:0] alu_res;
  logic              alu_zero;
  logic              alu_ovf;
  logic              alu_inv;
  logic              aceita;
  logic              drena;

  alu_nucleo #(.DATA_W(DATA_W)) u_alu (
    .codigo    (Controle_ALU),
    .op_a      (Operando_A),
    .op_b      (Operando_B),
    .resultado (alu_res),
    .zero      (alu_zero),
    .overflow  (alu_ovf),
    .invalido  (alu_inv)
  );

  always_comb begin
    novo.res  = alu_res;
    novo.zero = alu_zero;
    novo.ovf  = alu_ovf;
    novo.inv  = alu_inv;
    novo.rd   = Reg_Destino;
    novo.we   = Escreve_Reg & ~alu_inv;
  end

  assign aceita = In_Valido & pronto_q;
  assign drena  = (estado_q != VAZIO) & Out_Pronto;

  always_comb begin
    estado_d = estado_q;
    saida_d  = saida_q;
    skid_d   = skid_q;
    // Flush leaves the data registers untouched so outputs hold while invalid.
    if (Flush) begin
      estado_d = VAZIO;
    end else begin
      case (estado_q)
        VAZIO: begin
          if (aceita) begin
            saida_d  = novo;
            estado_d = UM;
          end
        end
        UM: begin
          if (aceita && !drena) begin
            skid_d   = novo;
            estado_d = CHEIO;
          end else if (aceita && drena) begin
            saida_d  = novo;
          end else if (drena) begin
            estado_d = VAZIO;
          end
        end
        CHEIO: begin
          if (drena) begin
            saida_d  = skid_q;
            estado_d = UM;
          end
        end
        default: estado_d = VAZIO;
      endcase
    end
    pronto_d = (estado_d != CHEIO);
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      estado_q <= VAZIO;
      pronto_q <= 1'b1;
      saida_q  <= '0;
      skid_q   <= '0;
    end else begin
      estado_q <= estado_d;
      pronto_q <= pronto_d;
      saida_q  <= saida_d;
      skid_q   <= skid_d;
    end
  end

  assign In_Pronto       = pronto_q;
  assign Out_Valido      = (estado_q != VAZIO);
  assign Resultado       = saida_q.res;
  assign Zero            = saida_q.zero;
  assign Overflow        = saida_q.ovf;
  assign Codigo_Invalido = saida_q.inv;
  assign Reg_Destino_Out = saida_q.rd;
  assign Escreve_Reg_Out = saida_q.we;

endmodule
